// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared encodings, decode result and lane helpers for arm_memory_ctrl
package arm_mem_pkg;
  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD} size_e;
  typedef enum logic [1:0] {CAUSE_NONE, CAUSE_UNMAPPED, CAUSE_MISALIGN, CAUSE_BADSIZE} cause_e;
  typedef enum logic [1:0] {REG_NONE, REG_DATA, REG_TEXT} region_e;
  typedef struct packed {
    logic [1:0] region;
    logic [3:0] mask;
    logic [1:0] shift;
    logic [1:0] cause;
  } dec_t;
  function automatic logic [31:0] lane_bits(logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction
endpackage

// File: rtl/arm_mem_decode.sv
// arm_mem_decode: per-port address/size decode into region, word index, big-endian lanes and fault cause
module arm_mem_decode
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] DATA_BASE = 32'h0000_0000,
  parameter int DATA_WORDS = 256,
  parameter logic [31:0] TEXT_BASE = 32'h0010_0000,
  parameter int TEXT_WORDS = 256,
  parameter int IW = 8
) (
  input  logic [31:0]   addr,
  input  logic [1:0]    size,
  output logic [1:0]    region,
  output logic [IW-1:0] idx,
  output logic [3:0]    mask,
  output logic [1:0]    shift,
  output logic [1:0]    cause
);
  logic [31:0] doff, toff;
  logic dhit, thit;
  // offsets wrap below the base, so one unsigned compare bounds both ends
  assign doff = addr - DATA_BASE;
  assign toff = addr - TEXT_BASE;
  assign dhit = doff < 32'(4 * DATA_WORDS);
  assign thit = toff < 32'(4 * TEXT_WORDS);
  assign region = dhit ? REG_DATA : thit ? REG_TEXT : REG_NONE;
  assign idx = dhit ? doff[IW+1:2] : toff[IW+1:2];
  assign mask = size == SIZE_BYTE ? 4'b1000 >> addr[1:0] :
                size == SIZE_HALF ? (addr[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign shift = size == SIZE_BYTE ? ~addr[1:0] :
                 size == SIZE_HALF ? (addr[1] ? 2'd0 : 2'd2) : 2'd0;
  assign cause = size == SIZE_RSVD ? CAUSE_BADSIZE :
                 (size == SIZE_HALF && addr[0]) || (size == SIZE_WORD && addr[1:0] != 2'b00) ? CAUSE_MISALIGN :
                 region == REG_NONE ? CAUSE_UNMAPPED : CAUSE_NONE;
endmodule

// File: rtl/arm_memory_ctrl.sv
// arm_memory_ctrl: dual-port data/text memory with req/ready handshake, registered responses and sticky fault capture
module arm_memory_ctrl
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] DATA_BASE = 32'h0000_0000,
  parameter int DATA_WORDS = 256,
  parameter logic [31:0] TEXT_BASE = 32'h0010_0000,
  parameter int TEXT_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req1,
  input  logic        we1,
  input  logic [1:0]  size1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ready1,
  output logic        rvalid1,
  output logic        err1,
  output logic [31:0] rdata1,
  input  logic        req2,
  input  logic        we2,
  input  logic [1:0]  size2,
  input  logic [31:0] addr2,
  input  logic [31:0] wdata2,
  output logic        ready2,
  output logic        rvalid2,
  output logic        err2,
  output logic [31:0] rdata2,
  output logic        excpt,
  output logic [31:0] excpt_addr,
  output logic [1:0]  excpt_cause,
  input  logic        excpt_clr
);
  localparam int DW = $clog2(DATA_WORDS);
  localparam int TW = $clog2(TEXT_WORDS);
  localparam int IW = DW > TW ? DW : TW;
  logic [1:0] req, we, acc, flt, wr, rvalid_q, err_q;
  logic [1:0] size [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rword [2];
  logic [31:0] rd [2];
  logic [31:0] wsh [2];
  logic [31:0] rdata_q [2];
  logic [IW-1:0] idx [2];
  dec_t d [2];
  logic coll;
  logic [31:0] data_mem [DATA_WORDS];
  logic [31:0] text_mem [TEXT_WORDS];
  assign req = {req2, req1};
  assign we = {we2, we1};
  assign size[0] = size1;
  assign size[1] = size2;
  assign addr[0] = addr1;
  assign addr[1] = addr2;
  assign wdata[0] = wdata1;
  assign wdata[1] = wdata2;
  for (genvar p = 0; p < 2; p++) begin : g_port
    arm_mem_decode #(
      .DATA_BASE(DATA_BASE), .DATA_WORDS(DATA_WORDS),
      .TEXT_BASE(TEXT_BASE), .TEXT_WORDS(TEXT_WORDS), .IW(IW)
    ) u_dec (
      .addr(addr[p]), .size(size[p]), .region(d[p].region), .idx(idx[p]),
      .mask(d[p].mask), .shift(d[p].shift), .cause(d[p].cause)
    );
    assign flt[p] = acc[p] && d[p].cause != CAUSE_NONE;
    assign wr[p] = acc[p] && we[p] && d[p].cause == CAUSE_NONE;
    assign rword[p] = d[p].region == REG_TEXT ? text_mem[idx[p][TW-1:0]] : data_mem[idx[p][DW-1:0]];
    assign rd[p] = (rword[p] & lane_bits(d[p].mask)) >> {d[p].shift, 3'b000};
    assign wsh[p] = wdata[p] << {d[p].shift, 3'b000};
  end
  // port 2 yields whenever the two ports touch one word and either writes
  assign coll = &req && |we && d[0].region != REG_NONE && d[0].region == d[1].region && idx[0] == idx[1];
  assign ready1 = rst;
  assign ready2 = rst && !coll;
  assign acc = req & {ready2, ready1};
  always_ff @(posedge clk)
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < 4; b++)
        if (wr[p] && d[p].mask[b])
          if (d[p].region == REG_TEXT) text_mem[idx[p][TW-1:0]][8*b +: 8] <= wsh[p][8*b +: 8];
          else data_mem[idx[p][DW-1:0]][8*b +: 8] <= wsh[p][8*b +: 8];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rvalid_q <= '0;
      err_q <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
      excpt <= 1'b0;
      excpt_addr <= '0;
      excpt_cause <= '0;
    end else begin
      rvalid_q <= acc;
      err_q <= flt;
      for (int p = 0; p < 2; p++) rdata_q[p] <= acc[p] && !we[p] && !flt[p] ? rd[p] : '0;
      if ((!excpt || excpt_clr) && |flt) begin
        excpt <= 1'b1;
        excpt_addr <= flt[0] ? addr[0] : addr[1];
        excpt_cause <= flt[0] ? d[0].cause : d[1].cause;
      end else if (excpt_clr) begin
        excpt <= 1'b0;
        excpt_addr <= '0;
        excpt_cause <= '0;
      end
    end
  assign rvalid1 = rvalid_q[0];
  assign rvalid2 = rvalid_q[1];
  assign err1 = err_q[0];
  assign err2 = err_q[1];
  assign rdata1 = rdata_q[0];
  assign rdata2 = rdata_q[1];
endmodule

// File: tb/tb_arm_memory_ctrl.sv
// tb_arm_memory_ctrl: randomized self-checking bench against a byte-addressed reference model
module tb_arm_memory_ctrl;
  localparam longint DB = 64'h0000_0000;
  localparam longint TB = 64'h0010_0000;
  localparam longint NW = 256;
  logic clk = 1'b0, rst = 1'b0;
  logic req1 = 0, we1 = 0, req2 = 0, we2 = 0, excpt_clr = 0;
  logic [1:0] size1 = 0, size2 = 0;
  logic [31:0] addr1 = 0, wdata1 = 0, addr2 = 0, wdata2 = 0;
  logic ready1, rvalid1, err1, ready2, rvalid2, err2, excpt;
  logic [31:0] rdata1, rdata2, excpt_addr;
  logic [1:0] excpt_cause;
  int checks = 0, errors = 0;
  logic [7:0] mem_m [logic [31:0]];
  bit m_excpt = 0;
  logic [31:0] m_eaddr = 0;
  logic [1:0] m_ecause = 0;

  arm_memory_ctrl dut (
    .clk(clk), .rst(rst),
    .req1(req1), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
    .ready1(ready1), .rvalid1(rvalid1), .err1(err1), .rdata1(rdata1),
    .req2(req2), .we2(we2), .size2(size2), .addr2(addr2), .wdata2(wdata2),
    .ready2(ready2), .rvalid2(rvalid2), .err2(err2), .rdata2(rdata2),
    .excpt(excpt), .excpt_addr(excpt_addr), .excpt_cause(excpt_cause), .excpt_clr(excpt_clr)
  );

  always #5 clk = ~clk;

  function automatic bit mapped(logic [31:0] a);
    longint la = longint'(a);
    return (la >= DB && la < DB + 4 * NW) || (la >= TB && la < TB + 4 * NW);
  endfunction

  function automatic logic [1:0] cause_of(logic [1:0] sz, logic [31:0] a);
    if (sz == 2'd3) return 2'd3;
    if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)) return 2'd2;
    if (!mapped(a)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] a, logic [1:0] sz);
    logic [31:0] v = 0;
    for (int k = 0; k < (1 << sz); k++) v = (v << 8) | 32'(mem_m[a + 32'(k)]);
    return v;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int n = 1 << sz;
    for (int k = 0; k < n; k++) mem_m[a + 32'(k)] = wd[8*(n-1-k) +: 8];
  endtask

  task automatic model_excpt(input bit f1, input logic [31:0] a1, input logic [1:0] c1,
                             input bit f2, input logic [31:0] a2, input logic [1:0] c2, input bit clr);
    if ((!m_excpt || clr) && (f1 || f2)) begin
      m_excpt = 1;
      m_eaddr = f1 ? a1 : a2;
      m_ecause = f1 ? c1 : c2;
    end else if (clr) begin
      m_excpt = 0;
      m_eaddr = 0;
      m_ecause = 0;
    end
  endtask

  function automatic logic [1:0] rnd_size();
    return $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
  endfunction

  function automatic logic [31:0] rnd_addr(logic [1:0] sz);
    logic [31:0] bnd [6] = '{32'h0000_03FC, 32'h0010_03FC, 32'h0000_0400, 32'h0010_0400, 32'h000F_FFFC, 32'hFFFF_FFFC};
    logic [31:0] a;
    int k = $urandom_range(0, 9);
    if (k < 4) a = 32'(DB) + $urandom_range(0, 1023);
    else if (k < 7) a = 32'(TB) + $urandom_range(0, 1023);
    else if (k == 7) a = bnd[$urandom_range(0, 5)];
    else if (k == 8) a = 32'h0080_0000 + $urandom_range(0, 255);
    else a = $urandom;
    if ($urandom_range(0, 4) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
    return a;
  endfunction

  task automatic single(input int p, input bit w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input bit clr);
    logic [1:0] c;
    logic [31:0] er;
    c = cause_of(sz, a);
    er = (c == 0 && !w) ? model_read(a, sz) : 32'h0;
    excpt_clr = clr;
    if (p == 0) begin req1 = 1; we1 = w; size1 = sz; addr1 = a; wdata1 = wd; end
    else begin req2 = 1; we2 = w; size2 = sz; addr2 = a; wdata2 = wd; end
    #1;
    checks++;
    if ((p == 0 ? ready1 : ready2) !== 1'b1) begin
      errors++; $display("FAIL ready%0d a=%h got=%b exp=1", p + 1, a, p == 0 ? ready1 : ready2);
    end
    @(posedge clk); #1;
    req1 = 0; req2 = 0; excpt_clr = 0;
    checks++;
    if ((p == 0 ? rvalid1 : rvalid2) !== 1'b1 || (p == 0 ? rvalid2 : rvalid1) !== 1'b0) begin
      errors++; $display("FAIL rvalid p%0d a=%h got=%b%b exp=one-hot", p + 1, a, rvalid2, rvalid1);
    end
    checks++;
    if ((p == 0 ? err1 : err2) !== (c != 0)) begin
      errors++; $display("FAIL err%0d a=%h sz=%0d got=%b exp=%b", p + 1, a, sz, p == 0 ? err1 : err2, c != 0);
    end
    checks++;
    if ((p == 0 ? rdata1 : rdata2) !== er) begin
      errors++; $display("FAIL rdata%0d a=%h sz=%0d w=%b got=%h exp=%h", p + 1, a, sz, w, p == 0 ? rdata1 : rdata2, er);
    end
    if (c == 0 && w) model_write(a, sz, wd);
    model_excpt(p == 0 && c != 0, a, c, p == 1 && c != 0, a, c, clr);
    checks++;
    if ({excpt, excpt_addr, excpt_cause} !== {m_excpt, m_eaddr, m_ecause}) begin
      errors++; $display("FAIL excpt after a=%h got=%b/%h/%0d exp=%b/%h/%0d", a, excpt, excpt_addr, excpt_cause, m_excpt, m_eaddr, m_ecause);
    end
  endtask

  task automatic dual(input bit w1, input logic [1:0] s1, input logic [31:0] a1, input logic [31:0] d1,
                      input bit w2, input logic [1:0] s2, input logic [31:0] a2, input logic [31:0] d2, input bit clr);
    logic [1:0] c1, c2;
    logic [31:0] e1, e2;
    bit coll;
    c1 = cause_of(s1, a1);
    c2 = cause_of(s2, a2);
    coll = mapped(a1) && mapped(a2) && a1[31:2] == a2[31:2] && (w1 || w2);
    e1 = (c1 == 0 && !w1) ? model_read(a1, s1) : 32'h0;
    e2 = (c2 == 0 && !w2) ? model_read(a2, s2) : 32'h0;
    req1 = 1; we1 = w1; size1 = s1; addr1 = a1; wdata1 = d1;
    req2 = 1; we2 = w2; size2 = s2; addr2 = a2; wdata2 = d2;
    excpt_clr = clr;
    #1;
    checks++;
    if ({ready1, ready2} !== {1'b1, !coll}) begin
      errors++; $display("FAIL ready pair a1=%h a2=%h got=%b%b exp=1%b", a1, a2, ready1, ready2, !coll);
    end
    @(posedge clk); #1;
    req1 = 0; excpt_clr = 0;
    checks++;
    if ({rvalid1, err1, rdata1} !== {1'b1, c1 != 0, e1}) begin
      errors++; $display("FAIL resp1 a=%h got=%b/%b/%h exp=1/%b/%h", a1, rvalid1, err1, rdata1, c1 != 0, e1);
    end
    checks++;
    if (coll ? rvalid2 !== 1'b0 : {rvalid2, err2, rdata2} !== {1'b1, c2 != 0, e2}) begin
      errors++; $display("FAIL resp2 a=%h coll=%b got=%b/%b/%h exp_err=%b exp_data=%h", a2, coll, rvalid2, err2, rdata2, c2 != 0, e2);
    end
    if (c1 == 0 && w1) model_write(a1, s1, d1);
    if (!coll && c2 == 0 && w2) model_write(a2, s2, d2);
    model_excpt(c1 != 0, a1, c1, !coll && c2 != 0, a2, c2, clr);
    checks++;
    if ({excpt, excpt_addr, excpt_cause} !== {m_excpt, m_eaddr, m_ecause}) begin
      errors++; $display("FAIL excpt dual got=%b/%h/%0d exp=%b/%h/%0d", excpt, excpt_addr, excpt_cause, m_excpt, m_eaddr, m_ecause);
    end
    req2 = 0;
    if (coll) single(1, w2, s2, a2, d2, 0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready1, ready2, rvalid1, rvalid2, err1, err2, rdata1, rdata2, excpt, excpt_addr, excpt_cause} !== '0) begin
      errors++; $display("FAIL reset state got rdy=%b%b rv=%b%b err=%b%b rd=%h/%h ex=%b/%h/%0d exp=all zero",
                         ready1, ready2, rvalid1, rvalid2, err1, err2, rdata1, rdata2, excpt, excpt_addr, excpt_cause);
    end
    rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_init();
    for (int i = 0; i < NW; i++) begin
      single(0, 1, 2'd2, 32'(DB) + 32'(4 * i), $urandom, 0);
      single(1, 1, 2'd2, 32'(TB) + 32'(4 * i), $urandom, 0);
    end
  endtask

  task automatic test_directed();
    single(0, 1, 2'd2, 32'h0000_0010, 32'h1122_3344, 0);
    for (int k = 0; k < 4; k++) single(1, 0, 2'd0, 32'h0000_0010 + 32'(k), 0, 0);
    single(0, 1, 2'd1, 32'h0010_0002, 32'h0000_BEEF, 0);
    single(0, 0, 2'd2, 32'h0010_0000, 0, 0);
    single(1, 0, 2'd1, 32'h0010_0000, 0, 0);
    single(0, 0, 2'd2, 32'h0000_0002, 0, 0);
    checks++;
    if ({excpt, excpt_addr, excpt_cause} !== {1'b1, 32'h2, 2'b10}) begin
      errors++; $display("FAIL misalign capture got=%b/%h/%0d exp=1/00000002/2", excpt, excpt_addr, excpt_cause);
    end
    single(1, 0, 2'd2, 32'h0020_0000, 0, 0);
    checks++;
    if (excpt_addr !== 32'h2) begin
      errors++; $display("FAIL sticky addr got=%h exp=00000002", excpt_addr);
    end
  endtask

  task automatic test_boundary();
    single(0, 1, 2'd2, 32'h0000_03FC, 32'hA5A5_0001, 0);
    single(1, 1, 2'd2, 32'h0010_03FC, 32'h5A5A_0002, 0);
    single(1, 0, 2'd2, 32'h0000_03FC, 0, 0);
    single(0, 0, 2'd0, 32'h0010_03FF, 0, 0);
    single(0, 1, 2'd2, 32'h0000_0400, 32'hDEAD_BEEF, 1);
    single(1, 0, 2'd2, 32'h000F_FFFC, 0, 1);
    single(0, 1, 2'd3, 32'h0000_0008, 32'hFFFF_FFFF, 1);
    single(1, 1, 2'd1, 32'h0000_0009, 32'hFFFF_FFFF, 0);
    single(0, 0, 2'd2, 32'h0000_0008, 0, 1);
  endtask

  task automatic test_collision();
    dual(1, 2'd2, 32'h0000_0040, 32'hCAFE_F00D, 0, 2'd2, 32'h0000_0040, 0, 0);
    dual(1, 2'd0, 32'h0010_0041, 32'h0000_0077, 1, 2'd0, 32'h0010_0042, 32'h0000_0088, 0);
    dual(0, 2'd2, 32'h0000_0044, 0, 0, 2'd1, 32'h0000_0046, 0, 0);
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a1, a2;
      logic [1:0] s1, s2;
      s1 = rnd_size();
      s2 = rnd_size();
      a1 = ($urandom_range(0, 1) ? 32'(TB) : 32'(DB)) + 32'(4 * $urandom_range(16, 19)) + $urandom_range(0, 3);
      a2 = $urandom_range(0, 3) == 0 ? rnd_addr(s2) : {a1[31:2], 2'(s2 == 2'd0 ? $urandom_range(0, 3) : 0)};
      if ($urandom_range(0, 3) != 0 && s1 != 2'd3) a1 = a1 & ~((32'd1 << s1) - 32'd1);
      dual($urandom_range(0, 1), s1, a1, $urandom, $urandom_range(0, 1), s2, a2, $urandom, $urandom_range(0, 7) == 0);
    end
  endtask

  task automatic test_fault_clear();
    single(0, 0, 2'd2, 32'h0000_0001, 0, 0);
    dual(0, 2'd2, 32'h0080_0000, 0, 0, 2'd3, 32'h0000_0044, 0, 1);
    checks++;
    if ({excpt, excpt_addr, excpt_cause} !== {1'b1, 32'h0080_0000, 2'b01}) begin
      errors++; $display("FAIL dual fault capture got=%b/%h/%0d exp=1/00800000/1", excpt, excpt_addr, excpt_cause);
    end
    single(1, 0, 2'd2, 32'h0000_0000, 0, 1);
    checks++;
    if (excpt !== 1'b0) begin
      errors++; $display("FAIL clear got=%b exp=0", excpt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [1:0] sz;
      sz = rnd_size();
      single($urandom_range(0, 1), $urandom_range(0, 1), sz, rnd_addr(sz), $urandom, $urandom_range(0, 7) == 0);
    end
  endtask

  task automatic test_reset_mid();
    single(0, 0, 2'd2, 32'hFFFF_FFF0, 0, 0);
    req1 = 1; we1 = 0; size1 = 2'd2; addr1 = 32'h0000_0010;
    @(posedge clk); #1;
    req1 = 0;
    rst = 0;
    #1;
    checks++;
    if ({rvalid1, rdata1, excpt, excpt_addr, excpt_cause, ready1, ready2} !== '0) begin
      errors++; $display("FAIL mid reset got rv=%b rd=%h ex=%b/%h/%0d rdy=%b%b exp=all zero",
                         rvalid1, rdata1, excpt, excpt_addr, excpt_cause, ready1, ready2);
    end
    m_excpt = 0; m_eaddr = 0; m_ecause = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    single(1, 0, 2'd2, 32'h0000_0010, 0, 0);
    single(0, 0, 2'd2, 32'h0010_0000, 0, 0);
  endtask

  initial begin
    test_reset();
    test_init();
    test_directed();
    test_boundary();
    test_collision();
    test_fault_clear();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
